// File: rtl/serial_command_receiver_pkg.sv
// Shared types and constants for the UART command receiver.
// Used by the receive front end and the command strobe logic.
package serial_command_receiver_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_SETUP,
        C_PULSE,
        C_GAP
    } cmd_state_t;

    localparam logic [7:0] CMD_MAX       = 8'h15;
    localparam logic [7:0] CMD_RESET_ALL = 8'hFF;
    localparam logic [4:0] IDX_RESET_ALL = 5'b11111;

    function automatic logic is_legal(input logic [7:0] b);
        return (b <= CMD_MAX) || (b == CMD_RESET_ALL);
    endfunction

    function automatic logic [4:0] to_index(input logic [7:0] b);
        return (b == CMD_RESET_ALL) ? IDX_RESET_ALL : b[4:0];
    endfunction

endpackage

// File: rtl/serial_command_receiver_uart_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, mid-bit sampling, frame check.
// valid/frame_error are decoded in the stop-sample cycle itself.
module uart_rx_byte
    import serial_command_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_error
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    rx_state_t     state;
    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          wait_high;
    logic          stop_tick;

    assign stop_tick   = (state == R_STOP) && (cnt == CNT_FULL);
    assign valid       = stop_tick && sync2;
    assign frame_error = stop_tick && !sync2;
    assign data        = shift;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            state     <= R_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            wait_high <= 1'b0;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            unique case (state)
                R_IDLE: begin
                    // after a bad stop bit, a held-low line must not restart a frame
                    if (wait_high) begin
                        if (sync2) begin
                            wait_high <= 1'b0;
                        end
                    end else if (!sync2) begin
                        state   <= R_START;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end
                end
                R_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= sync2 ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt     <= '0;
                        shift   <= {sync2, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= R_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        state <= R_IDLE;
                        if (!sync2) begin
                            wait_high <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/serial_command_receiver.sv
// Validates UART command bytes and turns each into one clean control strobe
// with a stable number, buffered through a single holding register.
module serial_command_receiver
    import serial_command_receiver_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [4:0] number,
    output logic       control,
    output logic       busy,
    output logic       frame_error,
    output logic       overrun,
    output logic       invalid
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int MAX_C = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW    = $clog2(MAX_C + 1);

    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ferr;
    logic          legal;
    logic          take;
    logic          held_full;
    logic [4:0]    held_idx;
    cmd_state_t    state;
    logic [TW-1:0] timer;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .data       (rx_data),
        .valid      (rx_valid),
        .frame_error(rx_ferr)
    );

    assign legal = is_legal(rx_data);
    assign take  = (state == C_IDLE) && held_full;
    assign busy  = (state != C_IDLE) || held_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            number      <= IDX_RESET_ALL;
            control     <= 1'b0;
            state       <= C_IDLE;
            timer       <= '0;
            held_full   <= 1'b0;
            held_idx    <= '0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            frame_error <= rx_ferr;
            invalid     <= rx_valid && !legal;
            // a byte landing while the register drains in this cycle still fits
            overrun     <= rx_valid && legal && held_full && !take;

            if (rx_valid && legal && (!held_full || take)) begin
                held_full <= 1'b1;
                held_idx  <= to_index(rx_data);
            end else if (take) begin
                held_full <= 1'b0;
            end

            unique case (state)
                C_IDLE: begin
                    if (held_full) begin
                        number <= held_idx;
                        state  <= C_SETUP;
                    end
                end
                C_SETUP: begin
                    control <= 1'b1;
                    timer   <= '0;
                    state   <= C_PULSE;
                end
                C_PULSE: begin
                    if (timer == PULSE_LAST) begin
                        control <= 1'b0;
                        timer   <= '0;
                        state   <= C_GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                C_GAP: begin
                    if (timer == GAP_LAST) begin
                        timer <= '0;
                        state <= C_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= C_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_command_receiver.sv
// Randomized UART stimulus against an event-level reference model, two pulse timings.
module tb_serial_command_receiver;

    localparam int CF   = 80;
    localparam int BD   = 10;
    localparam int CPB  = CF / BD;
    localparam int HALF = CPB / 2;
    localparam int P0   = 4;
    localparam int G0   = 4;
    localparam int P1   = 100;
    localparam int G1   = 100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [4:0] num [2];
    logic       ctl [2];
    logic       bsy [2];
    logic       fe  [2];
    logic       ovr [2];
    logic       inv [2];

    serial_command_receiver #(
        .CLK_FREQ(CF), .BAUD(BD), .PULSE_CYCLES(P0), .GAP_CYCLES(G0)
    ) d0 (
        .clock(clock), .reset(reset), .rx(rx), .number(num[0]),
        .control(ctl[0]), .busy(bsy[0]), .frame_error(fe[0]),
        .overrun(ovr[0]), .invalid(inv[0])
    );

    serial_command_receiver #(
        .CLK_FREQ(CF), .BAUD(BD), .PULSE_CYCLES(P1), .GAP_CYCLES(G1)
    ) d1 (
        .clock(clock), .reset(reset), .rx(rx), .number(num[1]),
        .control(ctl[1]), .busy(bsy[1]), .frame_error(fe[1]),
        .overrun(ovr[1]), .invalid(inv[1])
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int plen(input int i);
        return (i == 0) ? P0 : P1;
    endfunction

    function automatic int glen(input int i);
        return (i == 0) ? G0 : G1;
    endfunction

    // kind: 0 control rise (with number), 1 invalid, 2 overrun, 3 frame error
    function automatic int ev(input int c, input int i, input int k, input int n);
        return ((c * 2 + i) * 4 + k) * 32 + n;
    endfunction

    int         obs[$];
    int         expq[$];
    bit         mon_on = 1'b0;
    logic       prev_ctl [2] = '{1'b0, 1'b0};
    logic [4:0] prev_num [2] = '{5'h1f, 5'h1f};
    int         width    [2] = '{0, 0};

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (mon_on) begin
                if (ctl[i] && !prev_ctl[i]) obs.push_back(ev(cyc, i, 0, int'(num[i])));
                if (inv[i]) obs.push_back(ev(cyc, i, 1, 0));
                if (ovr[i]) obs.push_back(ev(cyc, i, 2, 0));
                if (fe[i])  obs.push_back(ev(cyc, i, 3, 0));
                if (!ctl[i] && prev_ctl[i]) check($sformatf("pulse_width%0d", i), width[i], plen(i));
                if (num[i] != prev_num[i]) check($sformatf("num_change_ctl%0d", i), ctl[i], 0);
            end
            if (ctl[i]) width[i] = prev_ctl[i] ? width[i] + 1 : 1;
            prev_ctl[i] = ctl[i];
            prev_num[i] = num[i];
        end
    end

    int         f_t[$];
    logic [7:0] f_b[$];
    bit         f_bad[$];

    // Stop bit is judged 1 edge + 2 sync + half bit + 9 full bits after the start bit is driven.
    task automatic send_frame(input logic [7:0] b, input bit bad, input int gap);
        f_t.push_back(cyc + 3 + HALF + 9 * CPB);
        f_b.push_back(b);
        f_bad.push_back(bad);
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      rx = 1'b0;
            else if (k == 9) rx = !bad;
            else             rx = b[k-1];
            repeat (CPB) @(negedge clock);
        end
        rx = 1'b1;
        repeat (gap) @(negedge clock);
    endtask

    task automatic send_glitch(input int len, input int gap);
        rx = 1'b0;
        repeat (len) @(negedge clock);
        rx = 1'b1;
        repeat (gap) @(negedge clock);
    endtask

    task automatic build_expected();
        for (int i = 0; i < 2; i++) begin
            bit held = 1'b0;
            int held_ld = 0;
            int free_at = 0;
            for (int j = 0; j < f_t.size(); j++) begin
                int t = f_t[j];
                logic [7:0] b = f_b[j];
                if (f_bad[j]) begin
                    expq.push_back(ev(t, i, 3, 0));
                end else if (!(b <= 8'h15 || b == 8'hff)) begin
                    expq.push_back(ev(t, i, 1, 0));
                end else if (held && held_ld > t) begin
                    expq.push_back(ev(t, i, 2, 0));
                end else begin
                    int ld = (t + 1 > free_at) ? t + 1 : free_at;
                    int n  = (b == 8'hff) ? 31 : int'(b[4:0]);
                    expq.push_back(ev(ld + 1, i, 0, n));
                    free_at = ld + 2 + plen(i) + glen(i);
                    held_ld = ld;
                    held = 1'b1;
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_number%0d", i), num[i], 5'h1f);
            check($sformatf("rst_control%0d", i), ctl[i], 0);
            check($sformatf("rst_busy%0d", i), bsy[i], 0);
            check($sformatf("rst_ferr%0d", i), fe[i], 0);
            check($sformatf("rst_ovr%0d", i), ovr[i], 0);
            check($sformatf("rst_inv%0d", i), inv[i], 0);
        end
        reset = 1'b0;
        mon_on = 1'b1;
        repeat (100) @(negedge clock);
        check("idle_busy", bsy[0], 0);

        send_frame(8'h05, 1'b0, 20);
        send_frame(8'h16, 1'b0, 5);
        send_frame(8'h40, 1'b0, 5);
        send_frame(8'hff, 1'b0, 20);
        send_frame(8'h03, 1'b1, 10);
        send_glitch(3, 20);
        send_frame(8'h01, 1'b0, 0);
        send_frame(8'h02, 1'b0, 0);
        send_frame(8'h03, 1'b0, 30);

        for (int r = 0; r < 30; r++) begin
            int sel = $urandom_range(0, 9);
            int gap = $urandom_range(0, 30);
            if (sel <= 4)       send_frame(8'($urandom_range(0, 21)), 1'b0, gap);
            else if (sel == 5)  send_frame(8'hff, 1'b0, gap);
            else if (sel <= 7)  send_frame(8'($urandom_range(22, 254)), 1'b0, gap);
            else if (sel == 8)  send_frame(8'($urandom), 1'b1, gap + 4);
            else                send_glitch($urandom_range(1, 3), gap + 10);
        end
        repeat (500) @(negedge clock);
        mon_on = 1'b0;
        check("end_busy0", bsy[0], 0);
        check("end_busy1", bsy[1], 0);

        build_expected();
        obs.sort();
        expq.sort();
        check("event_count", obs.size(), expq.size());
        for (int j = 0; j < obs.size() && j < expq.size(); j++)
            check($sformatf("event%0d", j), obs[j], expq[j]);

        send_frame(8'h05, 1'b0, 0);
        begin
            int n = 0;
            while (!ctl[0] && n < 50) begin
                @(negedge clock);
                n++;
            end
        end
        check("pulse_before_reset", ctl[0], 1);
        check("pulse_number", num[0], 5'h05);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("midrst_control%0d", i), ctl[i], 0);
            check($sformatf("midrst_number%0d", i), num[i], 5'h1f);
            check($sformatf("midrst_busy%0d", i), bsy[i], 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
